// File: rtl/aidc_lite_bf16_comp.sv
// -----------------------------------------------------------------------------
// aidc_lite_bf16_comp
//
// Fixed-ratio 2:1 block compressor. A 128-byte block (32 x FP32) is captured
// through a byte-enabled 16 x 64-bit write port. A start pulse converts every
// FP32 word to BF16, one 64-bit entry per cycle over 16 cycles. The resulting
// 64-byte block (16 x 32-bit) is then read through a pop-style port.
//
// Build option:
//   AIDC_LITE_BF16_RNE_EN  defined     : round-to-nearest-even with quiet NaN
//                          not defined : plain truncation (x[31:16])
//
// Ports:
//   clk           in   1   clock, rising edge
//   rst_n         in   1   asynchronous active-low reset
//   buf_wren_i    in   1   input buffer write strobe
//   buf_waddr_i   in   4   input buffer entry index
//   buf_wbe_i     in   8   byte enables, bit n covers buf_wdata_i[8n+7:8n]
//   buf_wdata_i   in  64   write data
//   comp_start_i  in   1   pulse: buffered block is complete, start conversion
//   comp_ready_o  out  1   compressed block available
//   comp_rden_i   in   1   pop strobe, advances to the next output word
//   comp_rdata_o  out 32   current output word
// -----------------------------------------------------------------------------
module aidc_lite_bf16_comp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        buf_wren_i,
  input  logic [3:0]  buf_waddr_i,
  input  logic [7:0]  buf_wbe_i,
  input  logic [63:0] buf_wdata_i,
  input  logic        comp_start_i,
  output logic        comp_ready_o,
  input  logic        comp_rden_i,
  output logic [31:0] comp_rdata_o
);

  localparam int ENTRIES = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  // FP32 -> BF16 conversion of one word.
  function automatic logic [15:0] cvt(input logic [31:0] x);
`ifdef AIDC_LITE_BF16_RNE_EN
    logic        round_up;
    logic [15:0] res;
    round_up = 1'b0;
    if ((x[30:23] == 8'hFF) && (x[22:0] != 23'd0)) begin
      // Any NaN becomes a quiet NaN; sign and upper payload bits kept.
      res = {x[31], 8'hFF, 1'b1, x[21:16]};
    end else begin
      // Mantissa carry ripples into the exponent; overflow to Inf is intended.
      round_up = x[15] & ((|x[14:0]) | x[16]);
      res      = x[31:16] + {15'd0, round_up};
    end
    return res;
`else
    return x[31:16];
`endif
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  rd_ptr_q, rd_ptr_d;
  logic        ready_q, ready_d;
  logic        conv_en_s;
  logic [31:0] cvt_word_s;

  logic [63:0] buf_q [ENTRIES];
  logic [63:0] buf_d [ENTRIES];
  logic [31:0] out_q [ENTRIES];
  logic [31:0] out_d [ENTRIES];

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= 4'd0;
      rd_ptr_q <= 4'd0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state logic: start, conversion sequencing and read pointer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rd_ptr_d  = rd_ptr_q;
    ready_d   = 1'b0;
    conv_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (comp_start_i) begin
          state_d = ST_CONV;
          idx_d   = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        // Start and pop are deliberately ignored while converting.
        conv_en_s = 1'b1;
        idx_d     = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d  = ST_READY;
          rd_ptr_d = 4'd0;
          ready_d  = 1'b1;
        end else begin
          state_d  = ST_CONV;
        end
      end
      ST_READY: begin
        // A restart wins over a pop issued in the same cycle.
        if (comp_start_i) begin
          state_d = ST_CONV;
          idx_d   = 4'd0;
          ready_d = 1'b0;
        end else if (comp_rden_i) begin
          rd_ptr_d = rd_ptr_q + 4'd1;
          ready_d  = 1'b1;
        end else begin
          ready_d  = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        idx_d    = 4'd0;
        rd_ptr_d = 4'd0;
        ready_d  = 1'b0;
      end
    endcase
  end

  // Next contents of the input buffer and the output store.
  always_comb begin
    buf_d = buf_q;
    out_d = out_q;
    // Conversion reads the registered buffer, so a same-cycle write to the
    // entry being converted is not seen until the next start.
    cvt_word_s = {cvt(buf_q[idx_q][63:32]), cvt(buf_q[idx_q][31:0])};
    if (conv_en_s) begin
      out_d[idx_q] = cvt_word_s;
    end else begin
      out_d[idx_q] = out_q[idx_q];
    end
    if (buf_wren_i) begin
      for (int b = 0; b < 8; b++) begin
        if (buf_wbe_i[b]) begin
          buf_d[buf_waddr_i][8*b +: 8] = buf_wdata_i[8*b +: 8];
        end else begin
          buf_d[buf_waddr_i][8*b +: 8] = buf_q[buf_waddr_i][8*b +: 8];
        end
      end
    end else begin
      buf_d[buf_waddr_i] = buf_q[buf_waddr_i];
    end
  end

  // Storage registers; both memories clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        buf_q[i] <= 64'd0;
        out_q[i] <= 32'd0;
      end
    end else begin
      buf_q <= buf_d;
      out_q <= out_d;
    end
  end

  assign comp_ready_o = ready_q;
  assign comp_rdata_o = out_q[rd_ptr_q];

endmodule

// File: tb/tb_aidc_lite_bf16_comp.sv
module tb_aidc_lite_bf16_comp;

`ifdef AIDC_LITE_BF16_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        buf_wren;
  logic [3:0]  buf_waddr;
  logic [7:0]  buf_wbe;
  logic [63:0] buf_wdata;
  logic        comp_start;
  logic        comp_ready;
  logic        comp_rden;
  logic [31:0] comp_rdata;

  aidc_lite_bf16_comp dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .buf_wren_i   (buf_wren),
    .buf_waddr_i  (buf_waddr),
    .buf_wbe_i    (buf_wbe),
    .buf_wdata_i  (buf_wdata),
    .comp_start_i (comp_start),
    .comp_ready_o (comp_ready),
    .comp_rden_i  (comp_rden),
    .comp_rdata_o (comp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [31:0] exp_rne;
    logic [31:0] exp_trn;
  } vec_t;

  vec_t vecs [16];
  int   n_vec;
  int   n_err;

  function automatic logic [31:0] exp_of(input vec_t v);
    return RNE ? v.exp_rne : v.exp_trn;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] be, input logic [63:0] d);
    buf_wren  = 1'b1;
    buf_waddr = a;
    buf_wbe   = be;
    buf_wdata = d;
    @(negedge clk);
    buf_wren  = 1'b0;
  endtask

  task automatic pop();
    comp_rden = 1'b1;
    @(negedge clk);
    comp_rden = 1'b0;
  endtask

  // Called just after the start edge; counts edges until ready rises.
  task automatic wait_ready(input bit noise, output int lat);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (noise) begin
        comp_start = (c == 5);
        comp_rden  = (c == 3) || (c == 6) || (c == 7);
      end
      @(negedge clk);
      comp_start = 1'b0;
      comp_rden  = 1'b0;
      if (comp_ready) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic start_wait(input bit noise, output int lat);
    comp_start = 1'b1;
    @(negedge clk);
    comp_start = 1'b0;
    wait_ready(noise, lat);
  endtask

  int lat;
  logic [31:0] be_exp;

  initial begin
    n_vec = 0;
    n_err = 0;
    //                 data                       RNE            trunc
    vecs[0]  = '{64'h3F800000_C0490FDB, 32'h3F80C049, 32'h3F80C049};
    vecs[1]  = '{64'h3F808000_3F818000, 32'h3F803F82, 32'h3F803F81};
    vecs[2]  = '{64'h7F7FFFFF_7F800001, 32'h7F807FC0, 32'h7F7F7F80};
    vecs[3]  = '{64'hFFC00000_80000000, 32'hFFC08000, 32'hFFC08000};
    vecs[4]  = '{64'h0000FFFF_FFFFFFFF, 32'h0001FFFF, 32'h0000FFFF};
    vecs[5]  = '{64'h3F80FFFF_7F80FFFF, 32'h3F817FC0, 32'h3F807F80};
    vecs[6]  = '{64'hBF7FFFFF_7F800000, 32'hBF807F80, 32'hBF7F7F80};
    vecs[7]  = '{64'h00018000_00008000, 32'h00020000, 32'h00010000};
    for (int i = 8; i < 15; i++) vecs[i] = vecs[0];
    vecs[15] = '{64'h40490FDB_00000000, 32'h40490000, 32'h40490000};
    be_exp = RNE ? 32'hAAAB3333 : 32'hAAAA3333;

    rst_n = 1'b0; buf_wren = 1'b0; buf_waddr = 4'd0; buf_wbe = 8'd0;
    buf_wdata = 64'd0; comp_start = 1'b0; comp_rden = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", {31'd0, comp_ready}, 32'd0);
    check("reset_rdata", comp_rdata, 32'd0);

    // Table vectors, with pops in IDLE and start/pops during CONV as noise.
    for (int i = 0; i < 16; i++) wr(i[3:0], 8'hFF, vecs[i].data);
    comp_rden = 1'b1;
    repeat (2) @(negedge clk);
    comp_rden = 1'b0;
    start_wait(1'b1, lat);
    check("table_latency", lat, 32'd16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("table_word%0d", i), comp_rdata, exp_of(vecs[i]));
      pop();
    end
    check("pop_wrap", comp_rdata, exp_of(vecs[0]));

    // Byte enables on entry 9, then restart with a simultaneous pop.
    repeat (3) pop();
    wr(4'd9, 8'hFF, 64'h11112222_33334444);
    wr(4'd9, 8'hF0, 64'hAAAAAAAA_55555555);
    comp_start = 1'b1;
    comp_rden  = 1'b1;
    @(negedge clk);
    comp_start = 1'b0;
    comp_rden  = 1'b0;
    check("restart_ready_drop", {31'd0, comp_ready}, 32'd0);
    wait_ready(1'b0, lat);
    check("restart_latency", lat, 32'd16);
    check("restart_rdptr0", comp_rdata, exp_of(vecs[0]));
    repeat (9) pop();
    check("byte_enable_word9", comp_rdata, be_exp);

    // Write entry 3 on the very edge that converts it.
    comp_start = 1'b1;
    @(negedge clk);
    comp_start = 1'b0;
    repeat (3) @(negedge clk);
    wr(4'd3, 8'hFF, 64'h3F800000_3F800000);
    wait_ready(1'b0, lat);
    check("hazard_latency", lat, 32'd12);
    repeat (3) pop();
    check("hazard_old_word3", comp_rdata, exp_of(vecs[3]));
    start_wait(1'b0, lat);
    check("hazard2_latency", lat, 32'd16);
    repeat (3) pop();
    check("hazard_new_word3", comp_rdata, 32'h3F803F80);

    // Reset at conversion cycle 7.
    comp_start = 1'b1;
    @(negedge clk);
    comp_start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midconv_rst_ready", {31'd0, comp_ready}, 32'd0);
    check("midconv_rst_rdata", comp_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, comp_ready}, 32'd0);

    // Basic block after reset.
    for (int i = 0; i < 16; i++) wr(i[3:0], 8'hFF, 64'h3F800000_C0490FDB);
    check("basic_pre_start_rdata", comp_rdata, 32'd0);
    start_wait(1'b0, lat);
    check("basic_latency", lat, 32'd16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("basic_word%0d", i), comp_rdata, 32'h3F80C049);
      pop();
    end
    check("basic_wrap", comp_rdata, 32'h3F80C049);
    check("basic_ready_held", {31'd0, comp_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
